// File: rtl/bitserial_alu_seq.sv
// Bit-serial ALU sequencer: LOAD, WIDTH shift cycles LSB first, DONE.
// Holds the 1-bit ALU slice plus the carry/zero flag registers.
module bitserial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic                     abort,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     sr_en,
    output logic                     sr_load,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    input  logic                     a_bit,
    input  logic                     b_bit,
    output logic                     res_bit,
    output logic                     carry,
    output logic                     zero
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wc_q, wc_d;
    logic          wz_q, wz_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;

    logic arith;
    logic b_eff;
    logic sum;
    logic cout;
    logic slice;

    // SUB is A + ~B + 1: the +1 comes from the carry preset in LOAD
    always_comb begin
        arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_eff = (op_q == OP_SUB) ? ~b_bit : b_bit;
        sum   = a_bit ^ b_eff ^ wc_q;
        cout  = (a_bit & b_eff) | (a_bit & wc_q) | (b_eff & wc_q);
        unique case (op_q)
            OP_ADD, OP_SUB: slice = sum;
            OP_AND:         slice = a_bit & b_bit;
            OP_OR:          slice = a_bit | b_bit;
            OP_XOR:         slice = a_bit ^ b_bit;
            OP_PASSB:       slice = b_bit;
            default:        slice = a_bit;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        wz_d    = wz_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d = '0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    wc_d    = (op_q == OP_SUB);
                    wz_d    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (arith) wc_d = cout;
                    wz_d = wz_q & ~slice;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                carry_d = arith ? wc_q : 1'b0;
                zero_d  = wz_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            wc_q    <= 1'b0;
            wz_q    <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            wz_q    <= wz_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done    = (state_q == S_DONE);
    assign sr_en   = busy;
    assign sr_load = (state_q == S_LOAD);
    assign bit_idx = idx_q;
    assign res_bit = (state_q == S_SHIFT) ? slice : 1'b0;
    assign carry   = carry_q;
    assign zero    = zero_q;

endmodule
